// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift op codes, per-slice control payload and log2 helper
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_ROR = 2'b01;
  localparam logic [1:0] SHIFT_SRL = 2'b10;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  // Control carried alongside the partial value; sign is the original operand MSB.
  typedef struct packed {
    logic [1:0] op;
    logic       sign;
  } shift_ctl_t;

  function automatic int log2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one register slice applying barrel levels LVL_LO..LVL_HI-1
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int SHAMT_W    = 5,
  parameter int LVL_LO     = 0,
  parameter int LVL_HI     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  i_take,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [SHAMT_W-1:0]    i_sh,
  input  shift_ctl_t            i_ctl,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [SHAMT_W-1:0]    o_sh,
  output shift_ctl_t            o_ctl,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  localparam logic [SHAMT_W-1:0] LVL_MASK =
    SHAMT_W'(((1 << LVL_HI) - 1) & ~((1 << LVL_LO) - 1));

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SHAMT_W-1:0]    r_sh;
  shift_ctl_t            r_ctl;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SHAMT_W-1:0]    w_sh;

  function automatic logic [DATA_WIDTH-1:0] level_shift(
    input logic [DATA_WIDTH-1:0] v,
    input shift_ctl_t            c,
    input int                    amt
  );
    case (c.op)
      SHIFT_SLL: level_shift = v << amt;
      SHIFT_ROR: level_shift = (v >> amt) | (v << (DATA_WIDTH - amt));
      SHIFT_SRL: level_shift = v >> amt;
      default:   level_shift = (v >> amt) | ({DATA_WIDTH{c.sign}} << (DATA_WIDTH - amt));
    endcase
  endfunction

  always_comb begin
    w_data = i_data;
    for (int k = LVL_LO; k < LVL_HI; k++) begin
      if (((i_sh >> k) & SHAMT_W'(1)) != '0) w_data = level_shift(w_data, i_ctl, 1 << k);
    end
  end

  // Consumed amount bits are cleared so later slices only see what is left.
  assign w_sh = i_sh & ~LVL_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sh    <= '0;
      r_ctl   <= '0;
      r_tag   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (i_take) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_data;
        r_sh   <= w_sh;
        r_ctl  <= i_ctl;
        r_tag  <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sh    = r_sh;
  assign o_ctl   = r_ctl;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined barrel shifter (sll/ror/srl/sra) with valid/ready, tag and flush
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [1:0]            in_op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int SHAMT_W = log2_f(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] w_data [0:PIPE_STAGES];
  logic [SHAMT_W-1:0]    w_sh   [0:PIPE_STAGES];
  shift_ctl_t            w_ctl  [0:PIPE_STAGES];
  logic [TAG_WIDTH-1:0]  w_tag  [0:PIPE_STAGES];
  logic [PIPE_STAGES:0]  w_valid;
  logic [PIPE_STAGES:0]  w_can;
  logic                  w_unused;

  assign w_data[0]  = in_a;
  assign w_sh[0]    = in_b[SHAMT_W-1:0];
  assign w_ctl[0]   = '{op: in_op, sign: in_a[DATA_WIDTH-1]};
  assign w_tag[0]   = in_tag;
  assign w_valid[0] = in_valid;

  // Slice i may load when some slice from i to the end is empty, or the result is taken.
  always_comb begin
    w_can = '0;
    w_can[PIPE_STAGES] = out_ready;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      w_can[i] = w_can[i+1] || !w_valid[i+1];
    end
  end

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    shift_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .SHAMT_W    (SHAMT_W),
      .LVL_LO     ((gi * SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES),
      .LVL_HI     (((gi + 1) * SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .i_take  (w_can[gi]),
      .i_valid (w_valid[gi]),
      .i_data  (w_data[gi]),
      .i_sh    (w_sh[gi]),
      .i_ctl   (w_ctl[gi]),
      .i_tag   (w_tag[gi]),
      .o_valid (w_valid[gi+1]),
      .o_data  (w_data[gi+1]),
      .o_sh    (w_sh[gi+1]),
      .o_ctl   (w_ctl[gi+1]),
      .o_tag   (w_tag[gi+1])
    );
  end

  assign in_ready   = !flush && w_can[0];
  assign out_valid  = w_valid[PIPE_STAGES];
  assign out_result = w_data[PIPE_STAGES];
  assign out_tag    = w_tag[PIPE_STAGES];

  assign w_unused = ^{w_sh[PIPE_STAGES], w_ctl[PIPE_STAGES], in_b[DATA_WIDTH-1:SHAMT_W]};

endmodule
